// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl -- stall / flush / memory-wait controller for a 5-stage pipeline.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   hazard_detected   stall request for the ID-stage instruction
//   branch_taken      taken branch/jump resolved in EXE this cycle
//   mem_req           MEM-stage instruction accesses data memory this cycle
//   mem_ready         data memory completes the access this cycle
//   freeze_PC         hold PC and IF/ID
//   bubble_ID_EXE     load a NOP into ID/EXE
//   flush_IF_ID       clear IF/ID to NOP
//   freeze_all        hold PC and every pipeline register
//   mem_error         sticky: a memory wait ran out of MEM_TIMEOUT cycles
//   stall_cnt, mem_wait_cnt, flush_cnt   saturating performance counters
//
// Configuration macro: STALL_COUNTERS_EN. When undefined the counter ports stay
// but are tied to zero and no counter flops exist.
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 200,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_PC,
  output logic             bubble_ID_EXE,
  output logic             flush_IF_ID,
  output logic             freeze_all,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] mem_wait_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic [WAIT_W-1:0] wait_inc;
  logic              err_set;
  logic              mem_stall;

  assign mem_stall = mem_req & ~mem_ready;
  assign wait_inc  = wait_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_error <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (err_set) mem_error <= 1'b1;
    end
  end

  // wait_cnt counts wait cycles already spent, including the RUN cycle that
  // first saw the stall; the MEM_WAIT cycle bringing it to MEM_TIMEOUT aborts.
  always_comb begin
    state_nxt     = state;
    wait_nxt      = wait_cnt;
    err_set       = 1'b0;
    freeze_PC     = 1'b0;
    bubble_ID_EXE = 1'b0;
    flush_IF_ID   = 1'b0;
    freeze_all    = 1'b0;
    if (rst) begin
      flush_IF_ID   = 1'b1;
      bubble_ID_EXE = 1'b1;
      state_nxt     = RUN;
      wait_nxt      = '0;
    end else begin
      case (state)
        MEM_WAIT: begin
          freeze_all = 1'b1;
          wait_nxt   = wait_inc;
          if (mem_ready) begin
            state_nxt = RUN;
            wait_nxt  = '0;
          end else if (wait_inc >= WAIT_W'(MEM_TIMEOUT)) begin
            err_set   = 1'b1;
            state_nxt = RUN;
            wait_nxt  = '0;
          end
        end
        RUN, FLUSH: begin
          // FLUSH behaves like RUN except the ID instruction is already a
          // bubble, so a hazard against it is meaningless.
          state_nxt = RUN;
          if (mem_stall) begin
            freeze_all = 1'b1;
            state_nxt  = MEM_WAIT;
            wait_nxt   = WAIT_W'(1);
          end else if (branch_taken) begin
            flush_IF_ID   = 1'b1;
            bubble_ID_EXE = 1'b1;
            state_nxt     = FLUSH;
          end else if (hazard_detected && (state == RUN)) begin
            freeze_PC     = 1'b1;
            bubble_ID_EXE = 1'b1;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

`ifdef STALL_COUNTERS_EN
  // freeze_PC is only ever raised by a hazard stall, so it marks stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt    <= '0;
      mem_wait_cnt <= '0;
      flush_cnt    <= '0;
    end else begin
      if (freeze_PC && (stall_cnt != '1))     stall_cnt    <= stall_cnt + 1'b1;
      if (freeze_all && (mem_wait_cnt != '1)) mem_wait_cnt <= mem_wait_cnt + 1'b1;
      if (flush_IF_ID && (flush_cnt != '1))   flush_cnt    <= flush_cnt + 1'b1;
    end
  end
`else
  assign stall_cnt    = '0;
  assign mem_wait_cnt = '0;
  assign flush_cnt    = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model of the control rules.
module tb_pipeline_ctrl;

  localparam int TO  = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hazard_detected = 1'b0;
  logic          branch_taken = 1'b0;
  logic          mem_req = 1'b0;
  logic          mem_ready = 1'b0;
  logic          freeze_PC, bubble_ID_EXE, flush_IF_ID, freeze_all, mem_error;
  logic [CW-1:0] stall_cnt, mem_wait_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  pipeline_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .hazard_detected(hazard_detected),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze_PC(freeze_PC), .bubble_ID_EXE(bubble_ID_EXE),
    .flush_IF_ID(flush_IF_ID), .freeze_all(freeze_all), .mem_error(mem_error),
    .stall_cnt(stall_cnt), .mem_wait_cnt(mem_wait_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // model: m_* is the state seen this cycle, p_* the state after the next edge
  bit m_wait = 0, m_flush = 0, m_err = 0;
  int m_waited = 0, m_sc = 0, m_mc = 0, m_fc = 0;
  bit p_wait = 0, p_flush = 0, p_err = 0;
  int p_waited = 0, p_sc = 0, p_mc = 0, p_fc = 0;
  bit e_fpc, e_bub, e_fl, e_fall;

  function automatic int sat_inc(input int v);
`ifdef STALL_COUNTERS_EN
    return (v < SAT) ? v + 1 : v;
`else
    return 0;
`endif
  endfunction

  function automatic logic [4:0] exp_ctl();
    return {e_fpc, e_bub, e_fl, e_fall, m_err};
  endfunction

  function automatic logic [3*CW-1:0] exp_cnt();
    return {CW'(m_sc), CW'(m_mc), CW'(m_fc)};
  endfunction

  function automatic logic [4:0] obs_ctl();
    return {freeze_PC, bubble_ID_EXE, flush_IF_ID, freeze_all, mem_error};
  endfunction

  function automatic logic [3*CW-1:0] obs_cnt();
    return {stall_cnt, mem_wait_cnt, flush_cnt};
  endfunction

  // Advance one cycle: apply inputs after the edge, predict, settle at negedge.
  task automatic step(input bit r, input bit hz, input bit br, input bit mq, input bit mr);
    @(posedge clk);
    #1;
    m_wait = p_wait; m_flush = p_flush; m_err = p_err; m_waited = p_waited;
    m_sc = p_sc; m_mc = p_mc; m_fc = p_fc;
    rst = r; hazard_detected = hz; branch_taken = br; mem_req = mq; mem_ready = mr;
    e_fpc = 0; e_bub = 0; e_fl = 0; e_fall = 0;
    p_wait = m_wait; p_flush = 0; p_err = m_err; p_waited = m_waited;
    p_sc = m_sc; p_mc = m_mc; p_fc = m_fc;
    if (r) begin
      e_fl = 1; e_bub = 1;
      p_wait = 0; p_waited = 0; p_err = 0; p_sc = 0; p_mc = 0; p_fc = 0;
    end else begin
      if (m_wait) begin
        e_fall = 1;
        p_waited = m_waited + 1;
        if (mr) p_wait = 0;
        else if (p_waited == TO) begin p_wait = 0; p_err = 1; end
      end else if (mq && !mr) begin
        e_fall = 1; p_wait = 1; p_waited = 1;
      end else if (br) begin
        e_fl = 1; e_bub = 1; p_flush = 1;
      end else if (hz && !m_flush) begin
        e_fpc = 1; e_bub = 1;
      end
      if (e_fpc)  p_sc = sat_inc(m_sc);
      if (e_fall) p_mc = sat_inc(m_mc);
      if (e_fl)   p_fc = sat_inc(m_fc);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    step(1, 1, 1, 1, 0);
    step(1, 1, 1, 1, 0);
    checks++;
    if (obs_ctl() !== 5'b01100) begin
      failures++; $display("FAIL reset_ctl got=%b want=%b", obs_ctl(), 5'b01100);
    end
    checks++;
    if (obs_cnt() !== '0) begin
      failures++; $display("FAIL reset_cnt got=%h want=0", obs_cnt());
    end
    step(0, 0, 0, 0, 0);
    checks++;
    if (obs_ctl() !== 5'b00000) begin
      failures++; $display("FAIL reset_release got=%b want=00000", obs_ctl());
    end
  endtask

  task automatic test_hazard();
    int want;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 0, 0, 0);
      checks++;
      if (obs_ctl() !== 5'b11000) begin
        failures++; $display("FAIL hazard_cyc%0d got=%b want=11000", i, obs_ctl());
      end
    end
    step(0, 0, 0, 0, 0);
`ifdef STALL_COUNTERS_EN
    want = 2;
`else
    want = 0;
`endif
    checks++;
    if (stall_cnt !== CW'(want)) begin
      failures++; $display("FAIL hazard_stall_cnt got=%0d want=%0d", stall_cnt, want);
    end
  endtask

  task automatic test_branch_priority();
    do_reset();
    step(0, 1, 1, 0, 0);
    checks++;
    if (obs_ctl() !== 5'b01100) begin
      failures++; $display("FAIL branch_prio got=%b want=01100", obs_ctl());
    end
    step(0, 1, 0, 0, 0);
    checks++;
    if (obs_ctl() !== 5'b00000) begin
      failures++; $display("FAIL flush_ignores_hazard got=%b want=00000", obs_ctl());
    end
    step(0, 1, 0, 0, 0);
    checks++;
    if (obs_ctl() !== exp_ctl()) begin
      failures++; $display("FAIL hazard_after_flush got=%b want=%b", obs_ctl(), exp_ctl());
    end
  endtask

  task automatic test_mem_wait();
    int want;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, (i == 3));
      checks++;
      if (obs_ctl() !== 5'b00010) begin
        failures++; $display("FAIL mem_wait_cyc%0d got=%b want=00010", i, obs_ctl());
      end
    end
    step(0, 0, 0, 0, 0);
`ifdef STALL_COUNTERS_EN
    want = 4;
`else
    want = 0;
`endif
    checks++;
    if ({freeze_all, mem_wait_cnt} !== {1'b0, CW'(want)}) begin
      failures++;
      $display("FAIL mem_wait_done got=%b/%0d want=0/%0d", freeze_all, mem_wait_cnt, want);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < TO; i++) begin
      step(0, 0, 0, 1, 0);
      checks++;
      if (obs_ctl() !== 5'b00010) begin
        failures++; $display("FAIL timeout_cyc%0d got=%b want=00010", i, obs_ctl());
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      checks++;
      if (obs_ctl() !== 5'b00001) begin
        failures++; $display("FAIL timeout_sticky%0d got=%b want=00001", i, obs_ctl());
      end
    end
  endtask

  task automatic test_branch_during_wait();
    logic [1:0] want [4] = '{2'b01, 2'b01, 2'b01, 2'b10};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, (i < 3), (i == 2));
      checks++;
      if ({flush_IF_ID, freeze_all} !== want[i]) begin
        failures++;
        $display("FAIL branch_wait_cyc%0d got=%b want=%b", i, {flush_IF_ID, freeze_all}, want[i]);
      end
    end
  endtask

  // Runs right after test_timeout, so mem_error starts at 1 and must clear.
  task automatic test_reset_mid_wait();
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    checks++;
    if ({flush_IF_ID, freeze_all} !== 2'b10) begin
      failures++; $display("FAIL rst_mid_wait got=%b want=10", {flush_IF_ID, freeze_all});
    end
    step(1, 0, 0, 1, 0);
    checks++;
    if ({mem_error, obs_cnt()} !== '0) begin
      failures++; $display("FAIL rst_mid_wait_clear got=%b/%h want=0/0", mem_error, obs_cnt());
    end
    step(0, 0, 0, 0, 0);
    checks++;
    if (obs_ctl() !== 5'b00000) begin
      failures++; $display("FAIL rst_mid_wait_run got=%b want=00000", obs_ctl());
    end
  endtask

  task automatic test_saturation();
    int want;
    do_reset();
    for (int i = 0; i < SAT + 5; i++) step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
`ifdef STALL_COUNTERS_EN
    want = SAT;
`else
    want = 0;
`endif
    checks++;
    if (stall_cnt !== CW'(want)) begin
      failures++; $display("FAIL stall_saturate got=%0d want=%0d", stall_cnt, want);
    end
  endtask

  task automatic test_random();
    bit r, hz, br, mq, mr;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      r  = ($urandom_range(63) == 0);
      hz = $urandom_range(1);
      br = ($urandom_range(3) == 0);
      mq = $urandom_range(1);
      mr = ($urandom_range(2) == 0);
      step(r, hz, br, mq, mr);
      checks++;
      if (obs_ctl() !== exp_ctl()) begin
        failures++; $display("FAIL rand_ctl cyc%0d got=%b want=%b", i, obs_ctl(), exp_ctl());
      end
      checks++;
      if (obs_cnt() !== exp_cnt()) begin
        failures++; $display("FAIL rand_cnt cyc%0d got=%h want=%h", i, obs_cnt(), exp_cnt());
      end
    end
  endtask

  initial begin
    test_reset();
    test_hazard();
    test_branch_priority();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_branch_during_wait();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
